// File: rtl/zeroheti_apb_mtimer.sv
// APB completer for the RISC-V machine timer: 64-bit mtime/mtimecmp, CTRL, level timer IRQ.
// Optional prescaler enabled by defining ZEROHETI_MTIMER_PRESC_EN.
module zeroheti_apb_mtimer #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned PrescWidth = 8,
    parameter logic [63:0] CmpRstVal  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic [31:0]          pwdata_i,
    input  logic [3:0]           pstrb_i,
    output logic [31:0]          prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,
    output logic                 timer_irq_o
);

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    localparam logic [2:0] RegMtimeLo = 3'd0;
    localparam logic [2:0] RegMtimeHi = 3'd1;
    localparam logic [2:0] RegCmpLo   = 3'd2;
    localparam logic [2:0] RegCmpHi   = 3'd3;
    localparam logic [2:0] RegCtrl    = 3'd4;

    state_e      state_q, state_d;
    logic [63:0] mtime_q, mtime_d, mtime_inc;
    logic [63:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic [31:0] shadow_q, shadow_d;
    logic        shadow_vld_q, shadow_vld_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pslverr_q, pslverr_d;
    logic        irq_q;
    logic        tick;
    logic        access;
    logic        mapped;
    logic [2:0]  offs;
    logic [31:0] ctrl_rd;
    logic        unused_addr;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? wdata[b*8 +: 8] : old[b*8 +: 8];
        end
        return res;
    endfunction

    assign offs        = paddr_i[4:2];
    assign mapped      = (offs <= RegCtrl);
    assign access      = (state_q == IDLE) && psel_i && penable_i;
    assign unused_addr = ^{paddr_i[AddrWidth-1:5], paddr_i[1:0]};
    assign mtime_inc   = mtime_q + {63'd0, tick};

`ifdef ZEROHETI_MTIMER_PRESC_EN
    logic [PrescWidth-1:0] presc_q, presc_d;
    logic [PrescWidth-1:0] cnt_q, cnt_d;
    logic                  ctrl_wr;

    assign ctrl_wr = access && pwrite_i && (offs == RegCtrl) && (|pstrb_i);
    assign tick    = en_q && (cnt_q == '0);

    always_comb begin
        presc_d = presc_q;
        if (ctrl_wr) begin
            for (int i = 0; i < PrescWidth; i++) begin
                presc_d[i] = pstrb_i[(8 + i) / 8] ? pwdata_i[8 + i] : presc_q[i];
            end
        end
    end

    // A CTRL write restarts the prescale period from the new reload value.
    always_comb begin
        cnt_d = cnt_q;
        if (ctrl_wr) begin
            cnt_d = presc_d;
        end else if (en_q) begin
            cnt_d = (cnt_q == '0) ? presc_q : cnt_q - PrescWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ctrl_rd                  = '0;
        ctrl_rd[0]               = en_q;
        ctrl_rd[8 +: PrescWidth] = presc_q;
    end
`else
    assign tick = en_q;

    // Without the prescaler the presc field reads as zero and ignores writes.
    always_comb begin
        ctrl_rd                  = '0;
        ctrl_rd[0]               = en_q;
        ctrl_rd[8 +: PrescWidth] = {PrescWidth{1'b0}};
    end
`endif

    always_comb begin
        state_d      = state_q;
        mtime_d      = mtime_inc;
        cmp_d        = cmp_q;
        en_d         = en_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        prdata_d     = '0;
        pslverr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    state_d   = RESP;
                    pslverr_d = !mapped;
                    if (pwrite_i) begin
                        // Written bytes override the tick; untouched bytes keep the increment.
                        case (offs)
                            RegMtimeLo: mtime_d[31:0]  = merge_bytes(mtime_inc[31:0], pwdata_i, pstrb_i);
                            RegMtimeHi: mtime_d[63:32] = merge_bytes(mtime_inc[63:32], pwdata_i, pstrb_i);
                            RegCmpLo:   cmp_d[31:0]    = merge_bytes(cmp_q[31:0], pwdata_i, pstrb_i);
                            RegCmpHi:   cmp_d[63:32]   = merge_bytes(cmp_q[63:32], pwdata_i, pstrb_i);
                            RegCtrl:    en_d           = pstrb_i[0] ? pwdata_i[0] : en_q;
                            default: ;
                        endcase
                    end else begin
                        case (offs)
                            RegMtimeLo: begin
                                prdata_d     = mtime_q[31:0];
                                shadow_d     = mtime_q[63:32];
                                shadow_vld_d = 1'b1;
                            end
                            RegMtimeHi: begin
                                prdata_d     = shadow_vld_q ? shadow_q : mtime_q[63:32];
                                shadow_vld_d = 1'b0;
                            end
                            RegCmpLo: prdata_d = cmp_q[31:0];
                            RegCmpHi: prdata_d = cmp_q[63:32];
                            RegCtrl:  prdata_d = ctrl_rd;
                            default: ;
                        endcase
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mtime_q      <= '0;
            cmp_q        <= CmpRstVal;
            en_q         <= 1'b0;
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
            prdata_q     <= '0;
            pslverr_q    <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mtime_q      <= mtime_d;
            cmp_q        <= cmp_d;
            en_q         <= en_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            prdata_q     <= prdata_d;
            pslverr_q    <= pslverr_d;
            irq_q        <= (mtime_q >= cmp_q);
        end
    end

    assign prdata_o    = prdata_q;
    assign pslverr_o   = pslverr_q;
    assign pready_o    = (state_q == RESP);
    assign timer_irq_o = irq_q;

endmodule
